// File: rtl/fft_frame_feeder_pkg.sv
// Shared types, limits and the point-count legality check for the FFT frame feeder.
package fft_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int unsigned PTS_MIN = 8;
  localparam int unsigned PTS_MAX = 1024;

  // Legal FFT lengths are powers of two inside [PTS_MIN, PTS_MAX].
  function automatic logic is_legal_pts(input logic [31:0] pts);
    logic pow2;
    pow2 = (pts != 32'd0) && ((pts & (pts - 32'd1)) == 32'd0);
    return pow2 && (pts >= PTS_MIN) && (pts <= PTS_MAX);
  endfunction

endpackage

// File: rtl/fft_frame_feeder_if.sv
// Streaming sink bus toward fft_gp.
// Handshake: a beat transfers on a rising clock edge where sink_valid and
// sink_ready are both high; while sink_valid is high and sink_ready is low the
// master holds data, sop and eop stable; sink_ready has zero ready latency.
interface fft_frame_feeder_if #(
  parameter int DW = 18
);
  logic          sink_valid;
  logic          sink_ready;
  logic          sink_sop;
  logic          sink_eop;
  logic [DW-1:0] sink_real;
  logic [DW-1:0] sink_imag;
  logic [1:0]    sink_error;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
    input  sink_ready
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
    output sink_ready
  );
endinterface

// File: rtl/fft_feeder_fifo.sv
// First-word-fall-through sample FIFO; full/empty come straight from a
// registered occupancy count, so both flags reflect the state before this
// cycle's push/pop.
module fft_feeder_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset discards any buffered samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, the reader masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Frames the free-running ADC sample stream into fixed-length packets for
// fft_gp: buffers in a small FIFO, marks sop/eop, runs a configured number of
// frames per start and reports done, overflow and configuration errors.
module fft_frame_feeder
  import fft_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DW         = 18,
  parameter int PW         = 11
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [PW-1:0]       cfg_pts,
  input  logic [15:0]         cfg_frames,
  input  logic                adc_valid,
  input  logic [DW-1:0]       adc_real,
  input  logic [DW-1:0]       adc_imag,
  fft_frame_feeder_if.master  sink,
  output logic [PW-1:0]       fftpts_in,
  output logic                inverse,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                cfg_err,
  output state_t              dbg_state
);

  state_t        state_q, state_d;
  logic [PW-1:0] pts_q, pts_d;
  logic [15:0]   frames_q, frames_d;
  logic [PW-1:0] in_idx_q, in_idx_d;
  logic [15:0]   in_frm_q, in_frm_d;
  logic [PW-1:0] out_idx_q, out_idx_d;
  logic [15:0]   out_frm_q, out_frm_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;
  logic          cfg_err_q, cfg_err_d;

  logic [2*DW-1:0] fifo_rd;
  logic            fifo_full, fifo_empty;
  logic            push, hs;
  logic [PW-1:0]   pts_m1;
  logic [15:0]     frames_m1;
  logic            out_last_idx;
  logic            cfg_legal;

  assign pts_m1       = pts_q - PW'(1);
  assign frames_m1    = frames_q - 16'd1;
  assign out_last_idx = (out_idx_q == pts_m1);
  assign cfg_legal    = is_legal_pts(32'(cfg_pts)) && (cfg_frames != 16'd0);

  // Samples enter only while RUN; the full flag is pre-pop, so a pop in the
  // same cycle does not make room for an incoming sample.
  assign push = (state_q == ST_RUN) && adc_valid && !fifo_full;
  assign hs   = !fifo_empty && sink.sink_ready;

  fft_feeder_fifo #(
    .WIDTH (2*DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push    (push),
    .wr_data ({adc_real, adc_imag}),
    .pop     (hs),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state logic: command decode, input/output counters and sticky flags.
  always_comb begin
    state_d    = state_q;
    pts_d      = pts_q;
    frames_d   = frames_q;
    in_idx_d   = in_idx_q;
    in_frm_d   = in_frm_q;
    out_idx_d  = out_idx_q;
    out_frm_d  = out_frm_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    cfg_err_d  = cfg_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_legal) begin
            pts_d      = cfg_pts;
            frames_d   = cfg_frames;
            in_idx_d   = '0;
            in_frm_d   = '0;
            out_idx_d  = '0;
            out_frm_d  = '0;
            overflow_d = 1'b0;
            cfg_err_d  = 1'b0;
            state_d    = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Dropped samples do not advance the counters, keeping frames whole.
        if (adc_valid && fifo_full) overflow_d = 1'b1;
        if (push) begin
          if (in_idx_q == pts_m1) begin
            in_idx_d = '0;
            in_frm_d = in_frm_q + 16'd1;
            if (in_frm_q == frames_m1) state_d = ST_DRAIN;
          end else begin
            in_idx_d = in_idx_q + PW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Input side is closed; only the output side below makes progress.
      end
      default: state_d = ST_IDLE;
    endcase

    if (hs && (state_q != ST_IDLE)) begin
      if (out_last_idx) begin
        out_idx_d = '0;
        out_frm_d = out_frm_q + 16'd1;
        if ((state_q == ST_DRAIN) && (out_frm_q == frames_m1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end else begin
        out_idx_d = out_idx_q + PW'(1);
      end
    end
  end

  // State, configuration, counters and flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pts_q      <= '0;
      frames_q   <= '0;
      in_idx_q   <= '0;
      in_frm_q   <= '0;
      out_idx_q  <= '0;
      out_frm_q  <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pts_q      <= pts_d;
      frames_q   <= frames_d;
      in_idx_q   <= in_idx_d;
      in_frm_q   <= in_frm_d;
      out_idx_q  <= out_idx_d;
      out_frm_q  <= out_frm_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Sink outputs; data is forced to zero while nothing is buffered so the
  // bus never shows stale or uninitialised FIFO contents.
  always_comb begin
    sink.sink_valid = !fifo_empty;
    sink.sink_sop   = !fifo_empty && (out_idx_q == '0);
    sink.sink_eop   = !fifo_empty && out_last_idx;
    sink.sink_real  = fifo_empty ? '0 : fifo_rd[2*DW-1:DW];
    sink.sink_imag  = fifo_empty ? '0 : fifo_rd[DW-1:0];
    sink.sink_error = 2'b00;
  end

  assign fftpts_in = pts_q;
  assign inverse   = 1'b0;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign cfg_err   = cfg_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench for fft_frame_feeder: expected beats are queued as samples
// are driven and compared as the DUT hands them over.
module tb_fft_frame_feeder;
  import fft_feeder_pkg::*;

  localparam int DW    = 18;
  localparam int PW    = 11;
  localparam int DEPTH = 16;
  localparam int W     = 2*DW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [PW-1:0] cfg_pts = '0;
  logic [15:0]   cfg_frames = '0;
  logic          adc_valid = 1'b0;
  logic [DW-1:0] adc_real = '0;
  logic [DW-1:0] adc_imag = '0;
  logic [PW-1:0] fftpts_in;
  logic          inverse, busy, done, overflow, cfg_err;
  state_t        dbg_state;

  fft_frame_feeder_if #(.DW(DW)) sif ();

  fft_frame_feeder #(
    .FIFO_DEPTH (DEPTH),
    .DW         (DW),
    .PW         (PW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .cfg_pts    (cfg_pts),
    .cfg_frames (cfg_frames),
    .adc_valid  (adc_valid),
    .adc_real   (adc_real),
    .adc_imag   (adc_imag),
    .sink       (sif.master),
    .fftpts_in  (fftpts_in),
    .inverse    (inverse),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .cfg_err    (cfg_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int fail_cnt  = 0;
  int cur_pts   = 8;
  int in_n      = 0;
  int beats     = 0;
  int sop_cnt   = 0;
  int eop_cnt   = 0;
  int done_cnt  = 0;
  int done0     = 0;
  bit prev_hs_eop = 1'b0;
  bit stall_pend  = 1'b0;
  bit chk_busy    = 1'b0;
  logic [W-1:0] held_beat = '0;

  // Compares whatever the DUT shows in the current cycle (called at negedge).
  task automatic monitor();
    logic [W-1:0] beat;
    logic [W-1:0] e;
    beat = {sif.sink_sop, sif.sink_eop, sif.sink_real, sif.sink_imag};
    if (chk_busy) begin
      tests_run++;
      if (busy !== 1'b1) begin
        fail_cnt++;
        $display("FAIL busy_after_start: got %b expected 1", busy);
      end
      chk_busy = 1'b0;
    end
    if (done === 1'b1) begin
      done_cnt++;
      tests_run++;
      if (prev_hs_eop !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0) begin
        fail_cnt++;
        $display("FAIL done_timing: prev_eop_hs=%b busy=%b pending=%0d expected 1/0/0",
                 prev_hs_eop, busy, exp_q.size());
      end
    end
    if (stall_pend) begin
      tests_run++;
      if (sif.sink_valid !== 1'b1 || beat !== held_beat) begin
        fail_cnt++;
        $display("FAIL stall_hold: got valid=%b beat=%h expected valid=1 beat=%h",
                 sif.sink_valid, beat, held_beat);
      end
    end
    prev_hs_eop = 1'b0;
    if (sif.sink_valid === 1'b1 && sif.sink_ready === 1'b1) begin
      beats++;
      stall_pend = 1'b0;
      if (sif.sink_sop === 1'b1) sop_cnt++;
      if (sif.sink_eop === 1'b1) begin
        eop_cnt++;
        prev_hs_eop = 1'b1;
      end
      tests_run++;
      if (exp_q.size() == 0) begin
        fail_cnt++;
        $display("FAIL beat_unexpected: got %h expected no beat", beat);
      end else begin
        e = exp_q.pop_front();
        if (beat !== e) begin
          fail_cnt++;
          $display("FAIL beat_data: got %h expected %h", beat, e);
        end
      end
    end else if (sif.sink_valid === 1'b1) begin
      stall_pend = 1'b1;
      held_beat  = beat;
    end else begin
      stall_pend = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic st, input logic v, input logic [DW-1:0] re,
                      input logic [DW-1:0] im, input logic rdy);
    @(posedge clk);
    #1;
    start          = st;
    adc_valid      = v;
    adc_real       = re;
    adc_imag       = im;
    sif.sink_ready = rdy;
    @(negedge clk);
    monitor();
  endtask

  task automatic push_exp(input logic [DW-1:0] re, input logic [DW-1:0] im);
    int idx;
    idx = in_n % cur_pts;
    exp_q.push_back({(idx == 0), (idx == cur_pts - 1), re, im});
    in_n++;
  endtask

  task automatic begin_run(input int pts, input int frames);
    cur_pts    = pts;
    cfg_pts    = PW'(pts);
    cfg_frames = 16'(frames);
    in_n = 0; beats = 0; sop_cnt = 0; eop_cnt = 0;
    done0 = done_cnt;
    exp_q.delete();
    step(1'b1, 1'b0, '0, '0, 1'b1);
    chk_busy = 1'b1;
  endtask

  // Drives until n more samples have been offered (and accepted, by construction).
  task automatic feed(input int n, input int vp, input bit rand_rdy);
    int target;
    logic v, rdy;
    logic [DW-1:0] re, im;
    target = in_n + n;
    while (in_n < target) begin
      v   = ($urandom_range(0, 7) < vp);
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      re  = DW'(in_n + 1);
      im  = DW'($urandom);
      if (v) push_exp(re, im);
      step(1'b0, v, v ? re : '0, v ? im : '0, rdy);
    end
  endtask

  task automatic finish_run(input int total, input int frames, input bit rand_rdy);
    int g;
    g = 0;
    while (done_cnt == done0 && g < 3000) begin
      step(1'b0, 1'b0, '0, '0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      g++;
    end
    tests_run++;
    if (done_cnt == done0) begin
      fail_cnt++;
      $display("FAIL done_timeout: got no done expected one pulse");
    end
    step(1'b0, 1'b0, '0, '0, 1'b1);
    tests_run++;
    if (beats != total || sop_cnt != frames || eop_cnt != frames || exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL run_framing: beats=%0d sop=%0d eop=%0d left=%0d expected %0d/%0d/%0d/0",
               beats, sop_cnt, eop_cnt, exp_q.size(), total, frames, frames);
    end
    tests_run++;
    if (done_cnt != done0 + 1 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      fail_cnt++;
      $display("FAIL run_end: done_pulses=%0d busy=%b state=%0d expected 1/0/0",
               done_cnt - done0, busy, dbg_state);
    end
  endtask

  task automatic check_reset_values(input string tag);
    tests_run++;
    if (sif.sink_valid !== 1'b0 || sif.sink_sop !== 1'b0 || sif.sink_eop !== 1'b0 ||
        sif.sink_real !== '0 || sif.sink_imag !== '0 || sif.sink_error !== 2'b00 ||
        fftpts_in !== '0 || inverse !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        overflow !== 1'b0 || cfg_err !== 1'b0 || dbg_state !== ST_IDLE) begin
      fail_cnt++;
      $display("FAIL %s: got v=%b sop=%b eop=%b re=%h im=%h err=%b pts=%0d inv=%b busy=%b done=%b ovf=%b cerr=%b st=%0d expected all 0",
               tag, sif.sink_valid, sif.sink_sop, sif.sink_eop, sif.sink_real, sif.sink_imag,
               sif.sink_error, fftpts_in, inverse, busy, done, overflow, cfg_err, dbg_state);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    sif.sink_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset_values");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("after_release");
  endtask

  task automatic test_single_frame();
    begin_run(8, 1);
    feed(8, 8, 1'b0);
    finish_run(8, 1, 1'b0);
    tests_run++;
    if (fftpts_in !== PW'(8)) begin
      fail_cnt++;
      $display("FAIL single_fftpts: got %0d expected 8", fftpts_in);
    end
  endtask

  task automatic test_random_ready();
    begin_run(64, 3);
    feed(192, 2, 1'b1);
    finish_run(192, 3, 1'b1);
    tests_run++;
    if (overflow !== 1'b0) begin
      fail_cnt++;
      $display("FAIL random_no_overflow: got %b expected 0", overflow);
    end
  endtask

  task automatic test_overflow();
    int s;
    logic rdy;
    logic [DW-1:0] im;
    begin_run(64, 2);
    s = 0;
    while (in_n < 128) begin
      s++;
      rdy = (s > 20);
      im  = DW'($urandom);
      // FIFO fills on steps 1..16; 17..20 stall; step 21 is still full pre-pop.
      if (s <= 16 || s >= 22) push_exp(DW'(s), im);
      step(1'b0, 1'b1, DW'(s), im, rdy);
      if (s == 17 || s == 18) begin
        tests_run++;
        if (overflow !== (s == 18)) begin
          fail_cnt++;
          $display("FAIL overflow_set step %0d: got %b expected %b", s, overflow, (s == 18));
        end
      end
    end
    finish_run(128, 2, 1'b0);
    tests_run++;
    if (overflow !== 1'b1) begin
      fail_cnt++;
      $display("FAIL overflow_sticky: got %b expected 1", overflow);
    end
  endtask

  task automatic test_cfg_err();
    int big;
    logic [PW-1:0] bad_pts [3];
    logic [15:0]   bad_frm [3];
    big = 2048;
    bad_pts[0] = PW'(100);      bad_frm[0] = 16'd1;
    bad_pts[1] = big[PW-1:0];   bad_frm[1] = 16'd1;
    bad_pts[2] = PW'(64);       bad_frm[2] = 16'd0;
    for (int i = 0; i < 3; i++) begin
      cfg_pts    = bad_pts[i];
      cfg_frames = bad_frm[i];
      step(1'b1, 1'b0, '0, '0, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b1);
      tests_run++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || overflow !== 1'b1) begin
        fail_cnt++;
        $display("FAIL cfg_err_case%0d: got cerr=%b busy=%b ovf=%b expected 1/0/1",
                 i, cfg_err, busy, overflow);
      end
    end
    begin_run(8, 1);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    tests_run++;
    if (cfg_err !== 1'b0 || overflow !== 1'b0) begin
      fail_cnt++;
      $display("FAIL cfg_err_clear: got cerr=%b ovf=%b expected 0/0", cfg_err, overflow);
    end
    feed(8, 8, 1'b0);
    finish_run(8, 1, 1'b0);
  endtask

  task automatic test_start_in_run();
    begin_run(16, 1);
    feed(5, 8, 1'b0);
    cfg_pts    = PW'(32);
    cfg_frames = 16'd5;
    step(1'b1, 1'b0, '0, '0, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    tests_run++;
    if (fftpts_in !== PW'(16) || cfg_err !== 1'b0 || busy !== 1'b1) begin
      fail_cnt++;
      $display("FAIL start_in_run: got pts=%0d cerr=%b busy=%b expected 16/0/1",
               fftpts_in, cfg_err, busy);
    end
    feed(11, 8, 1'b0);
    finish_run(16, 1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int g;
    logic [DW-1:0] im;
    begin_run(64, 1);
    g = 0;
    while (beats < 30 && g < 200) begin
      im = DW'($urandom);
      push_exp(DW'(in_n + 1), im);
      step(1'b0, 1'b1, DW'(in_n), im, 1'b1);
      g++;
    end
    @(posedge clk);
    #2;
    reset_n   = 1'b0;
    adc_valid = 1'b0;
    #1;
    check_reset_values("reset_async");
    exp_q.delete();
    stall_pend  = 1'b0;
    prev_hs_eop = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b0, '0, '0, 1'b1);
    check_reset_values("reset_fifo_empty");
    begin_run(8, 1);
    feed(8, 8, 1'b0);
    finish_run(8, 1, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    sif.sink_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_random_ready();
    test_overflow();
    test_cfg_err();
    test_start_in_run();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
